// File: rtl/nf10_packet_expander_pkg.sv
// Shared types and helpers for the packet expander: FSM encoding, length type,
// and strobe/byte-count conversions sized for the widest supported beat.
package nf10_packet_expander_pkg;

    // Widest supported beat is 256 bits; narrower beats use the low bits.
    localparam int BYTES_PER_BEAT = 32;
    localparam int LEN_WIDTH      = 16;

    typedef logic [LEN_WIDTH-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    function automatic len_t popcount_strb(input logic [BYTES_PER_BEAT-1:0] strb);
        len_t n;
        n = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            n = n + len_t'(strb[i]);
        end
        return n;
    endfunction

    function automatic logic [BYTES_PER_BEAT-1:0] strb_from_count(input len_t n);
        logic [BYTES_PER_BEAT-1:0] s;
        s = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            s[i] = (len_t'(i) < n);
        end
        return s;
    endfunction

endpackage

// File: rtl/nf10_pad_beat_gen.sv
// Builds one output beat: the low i_in_cnt bytes come from i_data, every byte
// above them is pad_byte, and the strobe covers the low i_out_cnt bytes.
module nf10_pad_beat_gen
    import nf10_packet_expander_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic [DATA_W-1:0]   i_data,
    input  len_t                i_in_cnt,
    input  len_t                i_out_cnt,
    input  logic [7:0]          i_pad_byte,
    output logic [DATA_W-1:0]   o_data,
    output logic [DATA_W/8-1:0] o_strb
);

    localparam int NB = DATA_W / 8;

    logic [BYTES_PER_BEAT-1:0] w_keep;
    logic [BYTES_PER_BEAT-1:0] w_strb;

    assign w_keep = strb_from_count(i_in_cnt);
    assign w_strb = strb_from_count(i_out_cnt);
    assign o_strb = w_strb[NB-1:0];

    always_comb begin
        o_data = '0;
        for (int k = 0; k < NB; k++) begin
            o_data[8*k +: 8] = w_keep[k] ? i_data[8*k +: 8] : i_pad_byte;
        end
    end

endmodule

// File: rtl/nf10_packet_expander.sv
// Restores truncated AXI4-Stream packets to the wire length carried in TUSER by
// appending pad bytes; pass-through beats are combinational, pad beats from FSM.
module nf10_packet_expander
    import nf10_packet_expander_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_LEN_LSB            = 0,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    input  logic                              expand_en,
    input  logic [7:0]                        pad_byte,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     expanded_pkts
);

    localparam int   L_BPB     = C_M_AXIS_DATA_WIDTH / 8;
    localparam len_t L_BPB_LEN = LEN_WIDTH'(L_BPB);

    state_t                        r_state;
    len_t                          r_byte_cnt;
    len_t                          r_target;
    len_t                          r_remaining;
    logic                          r_en;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_expanded_pkts;

    logic                          w_first;
    len_t                          w_len_in;
    len_t                          w_target;
    logic                          w_en;
    len_t                          w_cur_before;
    len_t                          w_pc;
    logic [LEN_WIDTH:0]            w_sum;
    len_t                          w_cur;
    len_t                          w_need;
    logic                          w_grow;
    logic                          w_extend;
    logic                          w_fill;
    len_t                          w_gen_in_cnt;
    len_t                          w_gen_out_cnt;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   w_gen_data;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] w_gen_strb;
    logic                          w_pad_last;
    logic                          w_s_xfer;
    logic                          w_m_xfer;

    assign w_first      = (r_state == ST_IDLE);
    assign w_len_in     = s_axis_tuser[C_LEN_LSB +: LEN_WIDTH];
    assign w_target     = w_first ? w_len_in  : r_target;
    assign w_en         = w_first ? expand_en : r_en;
    assign w_cur_before = w_first ? '0        : r_byte_cnt;
    assign w_pc         = popcount_strb(BYTES_PER_BEAT'(s_axis_tstrb));
    assign w_sum        = {1'b0, w_cur_before} + {1'b0, w_pc};
    assign w_cur        = w_sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : w_sum[LEN_WIDTH-1:0];
    assign w_need       = w_target - w_cur;

    // Growth is only possible when target exceeds cur, so the sum cannot have saturated.
    assign w_grow   = s_axis_tlast && w_en && (w_target > w_cur);
    assign w_extend = w_grow && (w_need <= (L_BPB_LEN - w_pc));
    assign w_fill   = w_grow && !(w_need <= (L_BPB_LEN - w_pc));

    assign w_pad_last = (r_remaining <= L_BPB_LEN);

    always_comb begin
        w_gen_in_cnt  = w_pc;
        w_gen_out_cnt = L_BPB_LEN;
        if (r_state == ST_PAD) begin
            w_gen_in_cnt  = '0;
            w_gen_out_cnt = w_pad_last ? r_remaining : L_BPB_LEN;
        end else if (w_extend) begin
            w_gen_out_cnt = w_target - w_cur_before;
        end
    end

    nf10_pad_beat_gen #(
        .DATA_W     (C_M_AXIS_DATA_WIDTH)
    ) u_pad_gen (
        .i_data     (s_axis_tdata),
        .i_in_cnt   (w_gen_in_cnt),
        .i_out_cnt  (w_gen_out_cnt),
        .i_pad_byte (pad_byte),
        .o_data     (w_gen_data),
        .o_strb     (w_gen_strb)
    );

    // Everything is forced low while reset is held so nothing leaks in the reset cycle.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        if (!axi_reset) begin
            case (r_state)
                ST_IDLE, ST_PASS: begin
                    s_axis_tready = m_axis_tready;
                    m_axis_tvalid = s_axis_tvalid;
                    m_axis_tdata  = w_grow ? w_gen_data : s_axis_tdata;
                    m_axis_tstrb  = w_grow ? w_gen_strb : s_axis_tstrb;
                    m_axis_tlast  = s_axis_tlast && !w_fill;
                    m_axis_tuser  = C_M_AXIS_TUSER_WIDTH'(s_axis_tuser);
                end
                ST_PAD: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = w_gen_data;
                    m_axis_tstrb  = w_gen_strb;
                    m_axis_tlast  = w_pad_last;
                end
                default: begin
                    m_axis_tvalid = 1'b0;
                end
            endcase
        end
    end

    assign w_s_xfer = s_axis_tvalid && s_axis_tready;
    assign w_m_xfer = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state         <= ST_IDLE;
            r_byte_cnt      <= '0;
            r_target        <= '0;
            r_remaining     <= '0;
            r_en            <= 1'b0;
            r_expanded_pkts <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PASS: begin
                    if (w_s_xfer) begin
                        if (w_first) begin
                            r_target <= w_len_in;
                            r_en     <= expand_en;
                        end
                        r_byte_cnt <= w_cur;
                        if (!s_axis_tlast) begin
                            r_state <= ST_PASS;
                        end else if (w_fill) begin
                            r_remaining <= w_target - w_cur_before - L_BPB_LEN;
                            r_state     <= ST_PAD;
                        end else begin
                            r_state <= ST_IDLE;
                            if (w_extend) begin
                                r_expanded_pkts <= r_expanded_pkts + C_S_AXI_DATA_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (w_m_xfer) begin
                        if (w_pad_last) begin
                            r_state         <= ST_IDLE;
                            r_expanded_pkts <= r_expanded_pkts + C_S_AXI_DATA_WIDTH'(1);
                        end else begin
                            r_remaining <= r_remaining - L_BPB_LEN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign expanded_pkts = r_expanded_pkts;

endmodule

// File: tb/tb_nf10_packet_expander.sv
// Directed bench for nf10_packet_expander: expected output beats are pushed to a
// queue per packet and compared by a monitor on the falling clock edge.
module tb_nf10_packet_expander;

    logic         clk = 1'b0;
    logic         axi_reset;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic         expand_en;
    logic [7:0]   pad_byte;
    logic [31:0]  expanded_pkts;

    nf10_packet_expander dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .expand_en     (expand_en),
        .pad_byte      (pad_byte),
        .expanded_pkts (expanded_pkts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic         l;
        logic [127:0] u;
        logic         pad;
    } beat_t;

    beat_t        exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         mon_en  = 1'b0;
    logic         tog     = 1'b0;
    logic         stalled = 1'b0;
    logic [255:0] prev_d;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int n, input logic [7:0] base, input logic [7:0] fill);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) begin
            r[8*k +: 8] = (k < n) ? (base + 8'(k)) : fill;
        end
        return r;
    endfunction

    task automatic push(input logic [255:0] d, input logic [31:0] s, input logic l,
                        input logic [127:0] u, input logic pad);
        beat_t b;
        b.d = d; b.s = s; b.l = l; b.u = u; b.pad = pad;
        exp_q.push_back(b);
    endtask

    task automatic drive_beat(input logic [255:0] d, input logic [31:0] s, input logic l,
                              input logic [127:0] u);
        logic done;
        done = 1'b0;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        chk("beat_accepted", {255'd0, done}, 256'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pkt60(input logic [127:0] len);
        push(mk(32, 8'h00, 8'hEE), 32'hFFFF_FFFF, 1'b0, len, 1'b0);
        push(mk(28, 8'h20, 8'hEE), 32'h0FFF_FFFF, 1'b1, '0, 1'b0);
        drive_beat(mk(32, 8'h00, 8'hEE), 32'hFFFF_FFFF, 1'b0, len);
        drive_beat(mk(28, 8'h20, 8'hEE), 32'h0FFF_FFFF, 1'b1, '0);
        drain();
    endtask

    task automatic pkt64_len100();
        push(mk(32, 8'h60, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd100, 1'b0);
        push(mk(32, 8'h80, 8'hEE), 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
        push({32{8'hAA}},          32'hFFFF_FFFF, 1'b0, '0, 1'b1);
        push({32{8'hAA}},          32'h0000_000F, 1'b1, '0, 1'b1);
        drive_beat(mk(32, 8'h60, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd100);
        drive_beat(mk(32, 8'h80, 8'hEE), 32'hFFFF_FFFF, 1'b1, '0);
        drain();
    endtask

    // Output monitor: checks every accepted beat and that stalled beats hold.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !axi_reset) begin
                if (stalled) begin
                    chk("hold_vld", {255'd0, m_axis_tvalid}, 256'd1);
                    chk("hold_data", m_axis_tdata, prev_d);
                end
                if (exp_q.size() == 0) begin
                    chk("idle_vld", {255'd0, m_axis_tvalid}, 256'd0);
                end else if (m_axis_tvalid && m_axis_tready) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("tdata", m_axis_tdata, e.d);
                    chk("tstrb", m_axis_tstrb, e.s);
                    chk("tlast", {255'd0, m_axis_tlast}, {255'd0, e.l});
                    chk("tuser", m_axis_tuser, e.u);
                    if (e.pad) chk("pad_sready", {255'd0, s_axis_tready}, 256'd0);
                end
                stalled = m_axis_tvalid && !m_axis_tready;
                prev_d  = m_axis_tdata;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = tog ? ~m_axis_tready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axi_reset     = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tdata  = mk(32, 8'h11, 8'h22);
        s_axis_tstrb  = 32'hFFFF_FFFF;
        s_axis_tuser  = 128'd77;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        expand_en     = 1'b1;
        pad_byte      = 8'h55;

        // Reset state: outputs forced low even with a valid input presented.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        chk("rst_sready", {255'd0, s_axis_tready}, 256'd0);
        chk("rst_tdata", m_axis_tdata, 256'd0);
        chk("rst_tstrb", m_axis_tstrb, 256'd0);
        chk("rst_tuser", m_axis_tuser, 256'd0);
        chk("rst_cnt", expanded_pkts, 256'd0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge clk);
        #1;
        axi_reset = 1'b0;
        mon_en    = 1'b1;
        @(posedge clk);
        #1;

        // Exact-length packet: untouched.
        pkt60(128'd60);
        chk("cnt_exact", expanded_pkts, 256'd0);

        // 40 bytes in, 60 wanted: last beat extended in place.
        pad_byte = 8'h00;
        push(mk(32, 8'h30, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd60, 1'b0);
        push(mk(8, 8'h40, 8'h00),  32'h0FFF_FFFF, 1'b1, '0, 1'b0);
        drive_beat(mk(32, 8'h30, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd60);
        drive_beat(mk(8, 8'h40, 8'hEE),  32'h0000_00FF, 1'b1, '0);
        drain();
        chk("cnt_extend", expanded_pkts, 256'd1);

        // 64 bytes in, 100 wanted: two extra pad beats.
        pad_byte = 8'hAA;
        pkt64_len100();
        chk("cnt_pad", expanded_pkts, 256'd2);

        // Same packet with downstream backpressure toggling every cycle.
        tog = 1'b1;
        pkt64_len100();
        tog = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt_pad_bp", expanded_pkts, 256'd3);

        // Expansion disabled at first beat; enabling mid-packet must not matter.
        expand_en = 1'b0;
        push(mk(32, 8'h01, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd1500, 1'b0);
        push(mk(8, 8'h50, 8'hEE),  32'h0000_00FF, 1'b1, '0, 1'b0);
        drive_beat(mk(32, 8'h01, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd1500);
        expand_en = 1'b1;
        drive_beat(mk(8, 8'h50, 8'hEE),  32'h0000_00FF, 1'b1, '0);
        drain();
        chk("cnt_disabled", expanded_pkts, 256'd3);

        // Length shorter than the data: no truncation.
        push(mk(32, 8'h02, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd20, 1'b0);
        push(mk(8, 8'h60, 8'hEE),  32'h0000_00FF, 1'b1, '0, 1'b0);
        drive_beat(mk(32, 8'h02, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd20);
        drive_beat(mk(8, 8'h60, 8'hEE),  32'h0000_00FF, 1'b1, '0);
        drain();

        // Zero target on a single-beat packet: pass-through.
        push(mk(10, 8'h70, 8'hEE), 32'h0000_03FF, 1'b1, 128'd0, 1'b0);
        drive_beat(mk(10, 8'h70, 8'hEE), 32'h0000_03FF, 1'b1, 128'd0);
        drain();
        chk("cnt_short", expanded_pkts, 256'd3);

        // Reset while padding a 200-byte packet.
        mon_en = 1'b0;
        drive_beat(mk(32, 8'h03, 8'hEE), 32'hFFFF_FFFF, 1'b0, 128'd200);
        drive_beat(mk(32, 8'h23, 8'hEE), 32'hFFFF_FFFF, 1'b1, '0);
        @(negedge clk);
        chk("pad_active", {255'd0, m_axis_tvalid}, 256'd1);
        @(posedge clk);
        #1;
        axi_reset = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        chk("midrst_sready", {255'd0, s_axis_tready}, 256'd0);
        @(posedge clk);
        #1;
        axi_reset = 1'b0;
        @(negedge clk);
        chk("postrst_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        chk("postrst_cnt", expanded_pkts, 256'd0);
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Fresh packet after reset starts from IDLE.
        pkt60(128'd60);
        chk("cnt_after_rst", expanded_pkts, 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
